// File: rtl/hwag_pkg.sv
// Shared types and constants for the angle-domain output blocks
// (crank angle generator and event scheduler).
package hwag_pkg;

    localparam int ANGLE_W   = 16;
    localparam int ANGLE_MAX = 3840;

    typedef logic [ANGLE_W-1:0] angle_t;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } sched_state_t;

endpackage

// File: rtl/angle_window_cmp.sv
// Registered angle-window test: flags when the angle lies inside [on, off),
// including windows that straddle the angle wrap.
module angle_window_cmp
    import hwag_pkg::*;
#(
    parameter int ANGLE_W   = hwag_pkg::ANGLE_W,
    parameter int ANGLE_MAX = hwag_pkg::ANGLE_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ANGLE_W-1:0] on,
    input  logic [ANGLE_W-1:0] off,
    input  logic [ANGLE_W-1:0] angle,
    output logic               active
);

    localparam logic [ANGLE_W-1:0] MAX_A = ANGLE_W'(ANGLE_MAX);

    logic hit_d;
    logic active_q;

    // on == off is an empty window, never a full revolution
    always_comb begin
        hit_d = 1'b0;
        if (angle < MAX_A) begin
            if (on < off) begin
                hit_d = (angle >= on) && (angle < off);
            end else if (on > off) begin
                hit_d = (angle >= on) || (angle < off);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
        end else begin
            active_q <= hit_d;
        end
    end

    assign active = active_q;

endmodule

// File: rtl/angle_event_scheduler.sv
// Drives ignition/injection channel outputs from the crank angle using one
// shared window comparator scanned round-robin across the channels.
//
// state | meaning
// HALT  | angle generator not synchronised; outputs off, shadow commits every clock
// SYNC  | angle valid, waiting for the first wrap to align to a revolution
// RUN   | scanning channels; shadow commits only at wrap
module angle_event_scheduler
    import hwag_pkg::*;
#(
    parameter int  N_CH      = 4,
    parameter int  ANGLE_W   = hwag_pkg::ANGLE_W,
    parameter int  ANGLE_MAX = hwag_pkg::ANGLE_MAX,
    localparam int CH_W      = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ANGLE_W-1:0] angle,
    input  logic               angle_valid,
    input  logic               angle_wrap,
    input  logic               cfg_wr,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic               cfg_field,
    input  logic [ANGLE_W-1:0] cfg_data,
    input  logic [N_CH-1:0]    ch_enable,
    output logic [N_CH-1:0]    coil_out,
    output logic [CH_W-1:0]    scan_ch,
    output logic               run,
    output logic               cfg_err
);

    localparam logic [ANGLE_W-1:0] MAX_A = ANGLE_W'(ANGLE_MAX);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic               commit;
    logic               scan_adv;
    logic [CH_W-1:0]    scan_q;
    logic [CH_W-1:0]    scan_d;

    logic [ANGLE_W-1:0] on_sh_q   [N_CH];
    logic [ANGLE_W-1:0] off_sh_q  [N_CH];
    logic [ANGLE_W-1:0] on_act_q  [N_CH];
    logic [ANGLE_W-1:0] off_act_q [N_CH];

    logic               cfg_bad;
    logic               cfg_ok;
    logic               cfg_err_q;

    logic [ANGLE_W-1:0] sel_on;
    logic [ANGLE_W-1:0] sel_off;
    logic               cmp_active;
    logic               cmp_vld_q;
    logic [CH_W-1:0]    cmp_ch_q;

    logic [N_CH-1:0]    coil_q;
    logic [N_CH-1:0]    coil_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= HALT;
        end else begin
            state_q <= state_d;
        end
    end

    // losing sync overrides every other transition
    always_comb begin
        state_d = state_q;
        if (!angle_valid) begin
            state_d = HALT;
        end else begin
            case (state_q)
                HALT:    state_d = SYNC;
                SYNC:    state_d = angle_wrap ? RUN : SYNC;
                RUN:     state_d = RUN;
                default: state_d = HALT;
            endcase
        end
    end

    always_comb begin
        run      = (state_q == RUN);
        commit   = (state_q == HALT) || ((state_q == RUN) && angle_wrap);
        scan_adv = (state_q == RUN) && (state_d == RUN);
    end

    assign cfg_bad = cfg_wr && (cfg_data >= MAX_A);
    assign cfg_ok  = cfg_wr && (cfg_data < MAX_A) && (32'(cfg_ch) < N_CH);

    // commit reads the shadow before this cycle's write lands
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                on_sh_q[i]   <= '0;
                off_sh_q[i]  <= '0;
                on_act_q[i]  <= '0;
                off_act_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (commit) begin
                    on_act_q[i]  <= on_sh_q[i];
                    off_act_q[i] <= off_sh_q[i];
                end
                if (cfg_ok && (cfg_ch == CH_W'(i))) begin
                    if (cfg_field) begin
                        off_sh_q[i] <= cfg_data;
                    end else begin
                        on_sh_q[i] <= cfg_data;
                    end
                end
            end
        end
    end

    always_comb begin
        scan_d = '0;
        if (scan_adv) begin
            scan_d = (scan_q == CH_W'(N_CH - 1)) ? '0 : scan_q + 1'b1;
        end
    end

    always_comb begin
        sel_on  = '0;
        sel_off = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (scan_q == CH_W'(i)) begin
                sel_on  = on_act_q[i];
                sel_off = off_act_q[i];
            end
        end
    end

    angle_window_cmp #(
        .ANGLE_W   (ANGLE_W),
        .ANGLE_MAX (ANGLE_MAX)
    ) u_cmp (
        .clk    (clk),
        .rst    (rst),
        .on     (sel_on),
        .off    (sel_off),
        .angle  (angle),
        .active (cmp_active)
    );

    // enable drop and loss of RUN act immediately, not at the scan slot
    always_comb begin
        coil_d = coil_q;
        if (cmp_vld_q) begin
            for (int i = 0; i < N_CH; i++) begin
                if (cmp_ch_q == CH_W'(i)) begin
                    coil_d[i] = cmp_active & ch_enable[i];
                end
            end
        end
        coil_d = coil_d & ch_enable;
        if ((state_q != RUN) || !angle_valid) begin
            coil_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_q    <= '0;
            cmp_vld_q <= 1'b0;
            cmp_ch_q  <= '0;
            coil_q    <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            scan_q    <= scan_d;
            cmp_vld_q <= run && angle_valid;
            cmp_ch_q  <= scan_q;
            coil_q    <= coil_d;
            cfg_err_q <= cfg_err_q | cfg_bad;
        end
    end

    assign coil_out = coil_q;
    assign scan_ch  = scan_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_angle_event_scheduler.sv
// Directed bench for angle_event_scheduler with a revolution-level reference
// model checked every cycle plus literal expectations at key angles.
module tb_angle_event_scheduler;
    import hwag_pkg::*;

    localparam int N_CH   = 4;
    localparam int M_HALT = 0;
    localparam int M_SYNC = 1;
    localparam int M_RUN  = 2;

    logic        clk = 1'b0;
    logic        rst;
    angle_t      angle;
    logic        angle_valid;
    logic        angle_wrap;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic        cfg_field;
    angle_t      cfg_data;
    logic [3:0]  ch_enable;
    logic [3:0]  coil_out;
    logic [1:0]  scan_ch;
    logic        run;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    angle_event_scheduler #(.N_CH(N_CH)) dut (
        .clk         (clk),
        .rst         (rst),
        .angle       (angle),
        .angle_valid (angle_valid),
        .angle_wrap  (angle_wrap),
        .cfg_wr      (cfg_wr),
        .cfg_ch      (cfg_ch),
        .cfg_field   (cfg_field),
        .cfg_data    (cfg_data),
        .ch_enable   (ch_enable),
        .coil_out    (coil_out),
        .scan_ch     (scan_ch),
        .run         (run),
        .cfg_err     (cfg_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // window as modular distance from the on angle
    function automatic bit in_window(input int on, input int off, input int a);
        int len;
        if (a >= ANGLE_MAX) return 1'b0;
        len = (off - on + ANGLE_MAX) % ANGLE_MAX;
        if (len == 0) return 1'b0;
        return ((a - on + ANGLE_MAX) % ANGLE_MAX) < len;
    endfunction

    // reference model, advanced at each clock edge
    int m_state = M_HALT;
    int m_scan  = 0;
    bit m_err   = 1'b0;
    int m_nxt;
    int sh_on  [N_CH];
    int sh_off [N_CH];
    int ac_on  [N_CH];
    int ac_off [N_CH];

    always @(posedge clk) begin
        if (rst) begin
            m_state = M_HALT;
            m_scan  = 0;
            m_err   = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                sh_on[i] = 0; sh_off[i] = 0; ac_on[i] = 0; ac_off[i] = 0;
            end
        end else begin
            if (m_state == M_HALT || (m_state == M_RUN && angle_wrap)) begin
                for (int i = 0; i < N_CH; i++) begin
                    ac_on[i]  = sh_on[i];
                    ac_off[i] = sh_off[i];
                end
            end
            if (cfg_wr) begin
                if (32'(cfg_data) >= ANGLE_MAX) m_err = 1'b1;
                else if (cfg_field) sh_off[cfg_ch] = 32'(cfg_data);
                else sh_on[cfg_ch] = 32'(cfg_data);
            end
            if (!angle_valid) m_nxt = M_HALT;
            else if (m_state == M_HALT) m_nxt = M_SYNC;
            else if (m_state == M_SYNC && angle_wrap) m_nxt = M_RUN;
            else m_nxt = m_state;
            m_scan  = (m_state == M_RUN && m_nxt == M_RUN) ? (m_scan + 1) % N_CH : 0;
            m_state = m_nxt;
        end
    end

    // compare process: settled outputs must match the ideal window level
    bit        chk_on     = 1'b0;
    bit        prev_force = 1'b1;
    bit [3:0]  prev_en    = 4'h0;
    bit [3:0]  ideal_prev = 4'h0;
    bit        running;
    bit        ideal;
    int        stab [N_CH];

    always @(negedge clk) begin
        if (chk_on) begin
            chk("run_model", 32'(run), 32'(m_state == M_RUN));
            chk("scan_ch_model", 32'(scan_ch), m_scan);
            chk("cfg_err_model", 32'(cfg_err), 32'(m_err));
            if (prev_force) chk("coil_forced_off", 32'(coil_out), 0);
            running = !rst && (m_state == M_RUN) && angle_valid;
            for (int i = 0; i < N_CH; i++) begin
                if (!prev_en[i]) chk("coil_enable_off", 32'(coil_out[i]), 0);
                ideal = running && ch_enable[i] && in_window(ac_on[i], ac_off[i], 32'(angle));
                if (ideal == ideal_prev[i]) stab[i]++;
                else stab[i] = 0;
                ideal_prev[i] = ideal;
                if (stab[i] >= N_CH + 2) chk("coil_settled", 32'(coil_out[i]), 32'(ideal));
            end
            prev_force = rst || (m_state != M_RUN) || !angle_valid;
            prev_en    = ch_enable;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ramp(input int from, input int to, input int per);
        for (int a = from; a <= to; a++) begin
            angle = angle_t'(a);
            step(per);
        end
    endtask

    task automatic wrap_pulse();
        angle      = '0;
        angle_wrap = 1'b1;
        step(1);
        angle_wrap = 1'b0;
    endtask

    task automatic cfg(input int ch, input bit field, input int data);
        cfg_wr    = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_field = field;
        cfg_data  = angle_t'(data);
        step(1);
        cfg_wr = 1'b0;
    endtask

    bit found;

    initial begin
        for (int i = 0; i < N_CH; i++) stab[i] = 0;
        rst = 1'b1; angle = '0; angle_valid = 1'b0; angle_wrap = 1'b0;
        cfg_wr = 1'b0; cfg_ch = '0; cfg_field = 1'b0; cfg_data = '0; ch_enable = 4'h0;
        step(2);
        chk_on = 1'b1;
        chk("reset_coil", 32'(coil_out), 0);
        chk("reset_run", 32'(run), 0);
        chk("reset_scan", 32'(scan_ch), 0);
        chk("reset_cfg_err", 32'(cfg_err), 0);
        rst = 1'b0;

        ramp(0, 40, 1);
        chk("unsync_coil", 32'(coil_out), 0);
        chk("unsync_run", 32'(run), 0);
        chk("unsync_scan", 32'(scan_ch), 0);

        cfg(0, 0, 100);  cfg(0, 1, 200);
        cfg(1, 0, 3800); cfg(1, 1, 50);
        cfg(2, 0, 500);  cfg(2, 1, 600);
        cfg(3, 0, 300);  cfg(3, 1, 300);
        ch_enable = 4'hF;

        angle_valid = 1'b1;
        angle = angle_t'(150);
        step(20);
        chk("sync_run", 32'(run), 0);
        chk("sync_no_coil", 32'(coil_out[0]), 0);

        wrap_pulse();
        chk("run_after_wrap", 32'(run), 1);
        ramp(90, 99, 8);
        chk("ch0_before_on", 32'(coil_out[0]), 0);
        angle = angle_t'(100);
        found = 1'b0;
        for (int k = 0; k < N_CH + 1; k++) begin
            step(1);
            if (coil_out[0]) found = 1'b1;
        end
        chk("ch0_rise_bound", 32'(found), 1);
        ramp(101, 199, 8);
        chk("ch0_in_window", 32'(coil_out[0]), 1);
        angle = angle_t'(200);
        found = 1'b0;
        for (int k = 0; k < N_CH + 1; k++) begin
            step(1);
            if (!coil_out[0]) found = 1'b1;
        end
        chk("ch0_fall_bound", 32'(found), 1);
        ramp(201, 210, 8);
        ramp(290, 310, 2);
        chk("ch3_empty_window", 32'(coil_out[3]), 0);

        ramp(3790, 3839, 2);
        chk("ch1_before_wrap", 32'(coil_out[1]), 1);
        wrap_pulse();
        ramp(1, 40, 2);
        chk("ch1_after_wrap", 32'(coil_out[1]), 1);
        ramp(41, 60, 2);
        chk("ch1_after_off", 32'(coil_out[1]), 0);

        ramp(490, 550, 2);
        cfg(2, 1, 700);
        ramp(551, 590, 2);
        chk("ch2_old_window_on", 32'(coil_out[2]), 1);
        ramp(591, 650, 2);
        chk("ch2_old_off_used", 32'(coil_out[2]), 0);
        wrap_pulse();
        ramp(640, 680, 2);
        chk("ch2_new_off_live", 32'(coil_out[2]), 1);
        ramp(681, 720, 2);
        chk("ch2_new_off_falls", 32'(coil_out[2]), 0);

        angle = '0; angle_wrap = 1'b1;
        cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_field = 1'b1; cfg_data = angle_t'(800);
        step(1);
        angle_wrap = 1'b0; cfg_wr = 1'b0;
        ramp(740, 760, 2);
        chk("ch2_wrap_write_deferred", 32'(coil_out[2]), 0);
        wrap_pulse();
        ramp(740, 760, 2);
        chk("ch2_wrap_write_commits", 32'(coil_out[2]), 1);
        ramp(761, 810, 2);
        chk("ch2_off800_falls", 32'(coil_out[2]), 0);

        cfg(0, 0, 3840);
        chk("cfg_err_set", 32'(cfg_err), 1);
        wrap_pulse();
        ramp(140, 160, 2);
        chk("ch0_unchanged_after_bad", 32'(coil_out[0]), 1);
        ramp(295, 305, 2);
        chk("ch3_on_eq_off", 32'(coil_out[3]), 0);

        wrap_pulse();
        ramp(140, 150, 2);
        chk("ch0_before_disable", 32'(coil_out[0]), 1);
        ch_enable = 4'b1110;
        step(1);
        chk("ch0_disable_next_clk", 32'(coil_out[0]), 0);
        ch_enable = 4'hF;
        step(8);
        chk("ch0_reenabled", 32'(coil_out[0]), 1);

        cfg(3, 0, 1000);
        cfg(3, 1, 1100);
        wrap_pulse();
        ramp(1040, 1050, 2);
        chk("ch3_active", 32'(coil_out[3]), 1);
        angle_valid = 1'b0;
        step(1);
        chk("drop_valid_coil", 32'(coil_out), 0);
        chk("drop_valid_halt", 32'(run), 0);
        step(3);

        angle_valid = 1'b1;
        step(2);
        wrap_pulse();
        ramp(140, 150, 2);
        chk("ch0_before_rst", 32'(coil_out[0]), 1);
        rst = 1'b1;
        step(1);
        chk("rst_coil", 32'(coil_out), 0);
        chk("rst_run", 32'(run), 0);
        chk("rst_cfg_err", 32'(cfg_err), 0);
        chk("rst_scan", 32'(scan_ch), 0);
        rst = 1'b0;
        step(3);
        wrap_pulse();
        ramp(140, 150, 2);
        chk("rst_run_again", 32'(run), 1);
        chk("rst_shadow_cleared", 32'(coil_out), 0);
        ramp(1040, 1050, 2);
        chk("rst_ch3_cleared", 32'(coil_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
